// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
//   OP_W  : width of the operation select bus
//   op_e  : operation encoding (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS)
package logic_gate_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_pipe_stage.sv
// One register slot of the valid/ready pipeline.
//   clk, rst_n  : clock and asynchronous active-low reset
//   up_valid    : valid offered by the previous slot (or the input)
//   up_data     : data offered by the previous slot (or the input)
//   up_ready    : this slot can load this cycle
//   valid, data : contents of this slot
//   down_ready  : the next slot (or the consumer) can take our contents
module logic_pipe_stage #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          valid,
  output logic [DW-1:0] data,
  input  logic          down_ready
);

  // The slot can load when it is empty or its current contents move on.
  assign up_ready = !valid || down_ready;

  // Valid follows the upstream valid on every load; data is only replaced
  // when a real item arrives so that a bubble leaves the old value in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : input handshake for op, a, b
//   op                  : operation select (see logic_gate_pipe_pkg::op_e)
//   a, b                : WIDTH-bit operands (b unused by NOT and PASS)
//   out_valid/out_ready : output handshake for f, f_zero
//   f                   : result
//   f_zero              : result is all zeros
// Latency is STAGES cycles; one result per cycle when the consumer never stalls.
module logic_gate_pipe
  import logic_gate_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             f_zero
);

  localparam int DW = WIDTH + 1;

  logic [WIDTH-1:0] result;
  logic [DW-1:0]    stage_in;

  // Operation decode. All eight codes are meaningful, so every input
  // pattern produces a defined result.
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

  // The zero flag is produced once here and travels with the data.
  assign stage_in = {(result == '0), result};

  // Each slot keeps its own handshake wires so the ready chain, which runs
  // from the output back to the input, is built from separate nets.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          vld;
    logic [DW-1:0] dat;
    logic          up_rdy;
    logic          up_vld;
    logic [DW-1:0] up_dat;
    logic          dn_rdy;

    if (k == 0) begin : g_first
      assign up_vld = in_valid;
      assign up_dat = stage_in;
    end else begin : g_mid
      assign up_vld = g_stage[k-1].vld;
      assign up_dat = g_stage[k-1].dat;
    end

    if (k == STAGES - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_inner
      assign dn_rdy = g_stage[k+1].up_rdy;
    end

    logic_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_vld),
      .up_data    (up_dat),
      .up_ready   (up_rdy),
      .valid      (vld),
      .data       (dat),
      .down_ready (dn_rdy)
    );
  end

  // The input is accepted whenever the first slot can load, which ripples
  // combinationally from the consumer through every full slot.
  assign in_ready  = g_stage[0].up_rdy;
  assign out_valid = g_stage[STAGES-1].vld;
  assign f         = g_stage[STAGES-1].dat[WIDTH-1:0];
  assign f_zero    = g_stage[STAGES-1].dat[WIDTH];

endmodule
